// File: rtl/datapath.sv
// ----------------------------------------------------------------------------
// datapath
//   Signed arithmetic/logic datapath for the neural-accelerator arithmetic
//   path. Two signed N-bit operands are combined according to a 3-bit opcode
//   into a saturated N-bit result and a carry/overflow flag. The result is
//   clamped to the representable range and never wraps.
//
//   The pipeline depth is chosen by PIPE:
//     0 : purely combinational, zero latency (clk/rst unused)
//     1 : result and flag registered at the output, latency 1
//     2 : operands/opcode registered at the input and result registered at
//         the output, latency 2
//   Any PIPE value above 2 behaves as 2.
//
// Ports
//   clk    : rising-edge clock for all pipeline registers
//   rst    : asynchronous active-high reset, clears every pipeline register
//   A, B   : signed N-bit operands
//   opcode : operation select (ADD SUB MUL RELU AND OR XOR PASS)
//   Y      : signed N-bit saturated result
//   co     : carry/overflow flag, set when an arithmetic result was clamped
// ----------------------------------------------------------------------------
module datapath #(
  parameter int N    = 16,
  parameter int PIPE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [N-1:0] A,
  input  logic signed [N-1:0] B,
  input  logic [2:0]          opcode,
  output logic signed [N-1:0] Y,
  output logic                co
);

  localparam int STAGES = (PIPE > 2) ? 2 : ((PIPE < 0) ? 0 : PIPE);

  // Saturation limits held at double width so they can be compared directly
  // against the exact sum, difference or full product.
  localparam logic signed [2*N-1:0] MAXP_W = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] MINN_W = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_RELU = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_PASS = 3'b111
  } opcode_e;

  logic signed [N-1:0]   coreA;
  logic signed [N-1:0]   coreB;
  opcode_e               coreOp;
  logic signed [2*N-1:0] extA;
  logic signed [2*N-1:0] extB;
  logic signed [2*N-1:0] wideRes;
  logic                  isArith;
  logic signed [N-1:0]   yD;
  logic                  coD;

  // Input stage: in the two-stage configuration the operands and opcode are
  // captured first; otherwise the core sees the ports directly. A cleared
  // input stage holds ADD 0+0, which naturally produces 0 with no overflow.
  generate
    if (STAGES == 2) begin : gInReg
      logic signed [N-1:0] aQ;
      logic signed [N-1:0] bQ;
      opcode_e             opQ;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          aQ  <= '0;
          bQ  <= '0;
          opQ <= OP_ADD;
        end else begin
          aQ  <= A;
          bQ  <= B;
          opQ <= opcode_e'(opcode);
        end
      end

      assign coreA  = aQ;
      assign coreB  = bQ;
      assign coreOp = opQ;
    end else begin : gInComb
      assign coreA  = A;
      assign coreB  = B;
      assign coreOp = opcode_e'(opcode);
    end
  endgenerate

  // Sign-extend to 2N bits: wide enough for the exact sum, difference and
  // full signed product, so overflow detection is a plain range compare.
  assign extA = {{N{coreA[N-1]}}, coreA};
  assign extB = {{N{coreB[N-1]}}, coreB};

  // Combinational core: arithmetic ops produce an exact wide result that is
  // then clamped; logic ops, RELU and PASS never overflow.
  always_comb begin
    wideRes = '0;
    isArith = 1'b0;
    yD      = '0;
    coD     = 1'b0;
    case (coreOp)
      OP_ADD: begin
        wideRes = extA + extB;
        isArith = 1'b1;
      end
      OP_SUB: begin
        wideRes = extA - extB;
        isArith = 1'b1;
      end
      OP_MUL: begin
        wideRes = extA * extB;
        isArith = 1'b1;
      end
      OP_RELU: yD = coreA[N-1] ? '0 : coreA;
      OP_AND:  yD = coreA & coreB;
      OP_OR:   yD = coreA | coreB;
      OP_XOR:  yD = coreA ^ coreB;
      OP_PASS: yD = coreA;
      default: yD = '0;
    endcase

    if (isArith) begin
      if (wideRes > MAXP_W) begin
        yD  = MAXP_W[N-1:0];
        coD = 1'b1;
      end else if (wideRes < MINN_W) begin
        yD  = MINN_W[N-1:0];
        coD = 1'b1;
      end else begin
        yD  = wideRes[N-1:0];
      end
    end
  end

  // Output stage: registered whenever at least one pipeline stage exists,
  // otherwise the core drives the outputs directly and clk/rst are idle.
  generate
    if (STAGES >= 1) begin : gOutReg
      logic signed [N-1:0] yQ;
      logic                coQ;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          yQ  <= '0;
          coQ <= 1'b0;
        end else begin
          yQ  <= yD;
          coQ <= coD;
        end
      end

      assign Y  = yQ;
      assign co = coQ;
    end else begin : gOutComb
      logic unusedClkRst;
      assign unusedClkRst = ^{clk, rst};
      assign Y  = yD;
      assign co = coD;
    end
  endgenerate

endmodule

// File: tb/tb_datapath.sv
// ----------------------------------------------------------------------------
// tb_datapath
//   Drives three datapath instances (PIPE = 0, 1, 2, all N = 16) with the same
//   operand stream and compares each against a behavioural model that works
//   on plain integers: exact result, then clamp to the signed 16-bit range.
//   The pipelined instances are compared against the model applied to the
//   operands issued one and two cycles earlier.
// ----------------------------------------------------------------------------
module tb_datapath;

  localparam int N = 16;
  localparam longint MAXP = (longint'(1) <<< (N-1)) - 1;
  localparam longint MINN = -(longint'(1) <<< (N-1));

  typedef struct {
    longint   a;
    longint   b;
    logic [2:0] op;
  } vec_t;

  typedef struct {
    longint y;
    longint co;
  } res_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [N-1:0] aIn = '0;
  logic signed [N-1:0] bIn = '0;
  logic [2:0]          opIn = 3'b000;

  logic signed [N-1:0] y0, y1, y2;
  logic                co0, co1, co2;

  int vectorCount = 0;
  int missCount   = 0;

  vec_t hist1;
  vec_t hist2;

  datapath #(.N(N), .PIPE(0)) dut0 (
    .clk(clk), .rst(rst), .A(aIn), .B(bIn), .opcode(opIn), .Y(y0), .co(co0)
  );
  datapath #(.N(N), .PIPE(1)) dut1 (
    .clk(clk), .rst(rst), .A(aIn), .B(bIn), .opcode(opIn), .Y(y1), .co(co1)
  );
  datapath #(.N(N), .PIPE(2)) dut2 (
    .clk(clk), .rst(rst), .A(aIn), .B(bIn), .opcode(opIn), .Y(y2), .co(co2)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural reference: compute the exact value with 64-bit integers and
  // clamp it; bitwise ops act on the sign-extended raw bits.
  function automatic res_t refModel(input vec_t v);
    res_t   r;
    longint exact;
    r.co  = 0;
    exact = 0;
    case (v.op)
      3'd0: exact = v.a + v.b;
      3'd1: exact = v.a - v.b;
      3'd2: exact = v.a * v.b;
      3'd3: exact = (v.a < 0) ? 0 : v.a;
      3'd4: exact = v.a & v.b;
      3'd5: exact = v.a | v.b;
      3'd6: exact = v.a ^ v.b;
      default: exact = v.a;
    endcase
    if (exact > MAXP) begin
      r.y  = MAXP;
      r.co = 1;
    end else if (exact < MINN) begin
      r.y  = MINN;
      r.co = 1;
    end else begin
      r.y = exact;
    end
    return r;
  endfunction

  // Single comparison point: counts every check and reports any miscompare.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One cycle of stimulus: at the falling edge first check the pipelined
  // outputs for what was issued one and two cycles ago, then issue the new
  // operands and check the combinational instance straight away.
  task automatic applyStimulus(input longint a, input longint b, input logic [2:0] op);
    vec_t v;
    res_t r;
    @(negedge clk);
    r = refModel(hist1);
    checkOutput("pipe1 Y",  longint'(y1),  r.y);
    checkOutput("pipe1 co", longint'(co1), r.co);
    r = refModel(hist2);
    checkOutput("pipe2 Y",  longint'(y2),  r.y);
    checkOutput("pipe2 co", longint'(co2), r.co);

    v.a  = a;
    v.b  = b;
    v.op = op;
    hist2 = hist1;
    hist1 = v;
    aIn  = N'(a);
    bIn  = N'(b);
    opIn = op;
    #1;
    r = refModel(v);
    checkOutput("pipe0 Y",  longint'(y0),  r.y);
    checkOutput("pipe0 co", longint'(co0), r.co);
  endtask

  task automatic clearHistory();
    hist1.a = 0; hist1.b = 0; hist1.op = 3'd0;
    hist2 = hist1;
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, " pipe1 Y"},  longint'(y1),  0);
    checkOutput({phase, " pipe1 co"}, longint'(co1), 0);
    checkOutput({phase, " pipe2 Y"},  longint'(y2),  0);
    checkOutput({phase, " pipe2 co"}, longint'(co2), 0);
  endtask

  initial begin
    logic signed [N-1:0] ra;
    logic signed [N-1:0] rb;
    longint              la;
    longint              lb;

    clearHistory();

    // Reset is asserted from time zero: outputs must be zero with no edge.
    #1;
    checkResetOutputs("power-on reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors covering each opcode and the saturation boundaries.
    applyStimulus(20000, 20000, 3'd0);
    applyStimulus(100, -300, 3'd0);
    applyStimulus(-32768, 1, 3'd1);
    applyStimulus(-32768, -1, 3'd2);
    applyStimulus(100, -50, 3'd2);
    applyStimulus(300, 200, 3'd2);
    applyStimulus(-5, 9, 3'd3);
    applyStimulus(7, -9, 3'd3);
    applyStimulus(16'sh00FF, 16'sh0F0F, 3'd4);
    applyStimulus(16'sh00FF, 16'sh0F0F, 3'd5);
    applyStimulus(16'sh00FF, 16'sh0F0F, 3'd6);
    applyStimulus(-123, 55, 3'd7);
    applyStimulus(32767, 0, 3'd0);
    applyStimulus(-32768, 0, 3'd0);
    applyStimulus(32767, -1, 3'd1);
    applyStimulus(-32768, -32768, 3'd2);
    // Back-to-back latency pair: ADD 3+4 then SUB 10-3, both give 7.
    applyStimulus(3, 4, 3'd0);
    applyStimulus(10, 3, 3'd1);

    // Randomized stream, biased towards the extremes now and then.
    for (int i = 0; i < 300; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if ($urandom_range(0, 7) == 0) ra = (ra[0]) ? 16'sh7FFF : 16'sh8000;
      if ($urandom_range(0, 7) == 0) rb = (rb[0]) ? 16'sh7FFF : -16'sd1;
      la = longint'(ra);
      lb = longint'(rb);
      applyStimulus(la, lb, 3'($urandom_range(0, 7)));
    end

    // Mid-stream asynchronous reset between edges.
    applyStimulus(1234, 4321, 3'd0);
    applyStimulus(-200, 300, 3'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("async reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset held");
    aIn  = '0;
    bIn  = '0;
    opIn = 3'd0;
    clearHistory();
    rst = 1'b0;

    // After release the history is empty (zeros), so any stale pre-reset
    // value on a pipelined output shows up as a miscompare.
    applyStimulus(1, 1, 3'd0);
    applyStimulus(5, 6, 3'd1);
    applyStimulus(-7, 3, 3'd2);
    applyStimulus(0, 0, 3'd7);
    applyStimulus(0, 0, 3'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
